key_debounce: RTL

Debounces and synchronises one raw mechanical push-button. Produces a clean level plus single-cycle press and release strobes. Sits directly upstream of the experiment-8 top-level state machine, which consumes `key_stable` and `key_press` to advance its sequence count. Press filtering is long to reject contact bounce. Release filtering is short so that rapid re-presses (2 ms gaps) are not lost.

---
 rtl/key_debounce.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-flop synchroniser, long press filter, short release filter,
// registered press/release strobes. Define KEY_LONG_PRESS_EN to build the long-press strobe.
`timescale 1ns/1ps
module key_debounce #(
  parameter int CNT_PER_MS = 50_000,
  parameter int PRESS_MS   = 20,
  parameter int RELEASE_MS = 1,
  parameter int LONG_MS    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic       key_stable,
  output logic       key_press,
  output logic       key_release,
  output logic       key_long,
  output logic [1:0] dbg_state
);

  localparam int N      = PRESS_MS * CNT_PER_MS;
  localparam int M      = RELEASE_MS * CNT_PER_MS;
  localparam int L      = LONG_MS * CNT_PER_MS;
  localparam int MAX_NM = (N > M) ? N : M;
  localparam int MAX_A  = (MAX_NM > L) ? MAX_NM : L;
  localparam int CW     = $clog2(MAX_A) + 1;

  localparam logic [CW-1:0] N_LAST = CW'(N - 1);
  localparam logic [CW-1:0] M_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_FILT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_FILT = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_key_stable;
  logic          r_key_press;
  logic          r_key_release;
  logic          w_ks;

  // Both flops idle high so reset release never looks like a press edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_ks = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RELEASED;
      r_cnt         <= '0;
      r_key_stable  <= 1'b1;
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
      case (r_state)
        S_RELEASED: begin
          if (!w_ks) begin
            r_state <= S_PRESS_FILT;
            r_cnt   <= '0;
          end
        end
        S_PRESS_FILT: begin
          if (w_ks) begin
            r_state <= S_RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == N_LAST) begin
            r_state      <= S_PRESSED;
            r_cnt        <= '0;
            r_key_stable <= 1'b0;
            r_key_press  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PRESSED: begin
          if (w_ks) begin
            r_state <= S_RELEASE_FILT;
            r_cnt   <= '0;
          end
        end
        S_RELEASE_FILT: begin
          // Falling back to PRESSED is a bounce: no strobe, level unchanged.
          if (!w_ks) begin
            r_state <= S_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == M_LAST) begin
            r_state       <= S_RELEASED;
            r_cnt         <= '0;
            r_key_stable  <= 1'b1;
            r_key_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CW-1:0] L_LAST = CW'(L - 1);
  localparam logic [CW-1:0] L_FULL = CW'(L);

  logic [CW-1:0] r_hold;
  logic          r_key_long;

  // Hold count parks at L after the strobe, so one key_long per press;
  // RELEASE_FILT keeps the count so a release bounce does not restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_key_long <= 1'b0;
    end else begin
      r_key_long <= 1'b0;
      if (r_state == S_RELEASED) begin
        r_hold <= '0;
      end else if ((r_state == S_PRESSED) && (r_hold != L_FULL)) begin
        r_hold     <= r_hold + CW'(1);
        r_key_long <= (r_hold == L_LAST);
      end
    end
  end

  assign key_long = r_key_long;
`else
  assign key_long = 1'b0;
`endif

  assign key_stable  = r_key_stable;
  assign key_press   = r_key_press;
  assign key_release = r_key_release;
  assign dbg_state   = r_state;

endmodule
